sdram_sample_prefetch: RTL
==========================

# sdram_sample_prefetch

Streaming read initiator for one 32-bit toggle-handshake port of the 2-word SDRAM controller, such as the ADPCM-A/B sample ports or sprite port. Given a byte range, it issues sequential 32-bit word requests, buffers returned words in a small FIFO, and delivers the range one byte at a time to a consumer such as an ADPCM decoder channel. It owns the `req` side of the toggle protocol. It tolerates restarts while a request is in flight.

## Interface
- `FIFO_DEPTH`, default 4: buffered 32-bit words; a power of 2, at least 2.
- `clk` in 1: single clock, same clock as the SDRAM controller.
- `init_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; latches the range, flushes the FIFO and starts a stream.
- `stop` in 1: one-cycle pulse; aborts the stream.
- `start_addr` in 26: first byte address. Bits [1:0] select the first byte lane.
- `end_addr` in 26: last byte address, inclusive.
- `rd` in 1: consumer pop of one byte; honoured only while `q_valid`=1.
- `q` out 8: current byte.
- `q_valid` out 1: `q` holds a byte of the range.
- `busy` out 1: a stream is active or a flush is pending.
- `done` out 1: one-cycle pulse after the last byte is popped.
- `mem_req` out 1: request toggle.
- `mem_ack` in 1: acknowledge toggle from the controller.
- `mem_addr` out 26: word-aligned byte address; bits [1:0] are always 0.
- `mem_q` in 32: returned word. Byte address a+0 is `mem_q`[7:0] and a+3 is `mem_q`[31:24].

## Operation
- Reset values: `mem_req`=0, `mem_addr`=0, `q`=0, `q_valid`=0, `busy`=0, `done`=0, FIFO empty, state IDLE.
- Handshake rules:
  - A request is outstanding while `mem_req`≠`mem_ack`.
  - A request is issued by toggling `mem_req` with `mem_addr` updated in the same cycle.
  - `mem_addr` holds stable while the request is outstanding.
  - At most one request is outstanding.
  - The block never assumes `mem_ack` equals `mem_req` after reset; it only compares them.
- Range setup on `start`:
  - word pointer = `start_addr`[25:2]
  - remaining-word counter (25 bit) = `end_addr`[25:2] − `start_addr`[25:2] + 1
  - lane = `start_addr`[1:0]
  - last = `end_addr` (the last byte address)
  - If `end_addr` < `start_addr`, the counter is 0.
- States:
  - IDLE:
    - `start` with a nonzero count → RUN if no request is outstanding, otherwise FLUSH.
    - `start` with a zero count → pulse `done`, stay IDLE.
  - RUN:
    - Issue a request when all of these hold: no request outstanding, counter>0, FIFO occupancy<`FIFO_DEPTH`. Then decrement the counter and increment the pointer.
    - On ack, write `mem_q` into the FIFO.
    - When the last byte is popped → IDLE and pulse `done`.
    - `stop` → FLUSH if a request is outstanding, otherwise IDLE.
    - `start` → restart; the FIFO is cleared and the target is FLUSH or RUN as in IDLE.
  - FLUSH:
    - Wait for `mem_ack`=`mem_req` and discard that word.
    - Then go to RUN if a restart is pending, otherwise IDLE.
    - `start` in FLUSH replaces the pending range; `stop` in FLUSH cancels the pending restart.
- Byte delivery:
  - `q_valid`=1 iff RUN and FIFO not empty.
  - `q` = byte [lane] of the head word.
  - `rd` increments lane (mod 4) and the byte address.
  - The head word pops when lane=3 or the popped byte address = last.
  - Only the first word starts at a nonzero lane.
- Priority: `start` > `stop` > `rd`.
- `done` never pulses on `stop` or restart.
- `busy` = state≠IDLE.

## Timing
- `start` at cycle N → `mem_req` toggles at N+1 with `mem_addr`=`start_addr`&~3 (when no request is outstanding).
- Ack detected at cycle M, meaning `mem_ack`==`mem_req` is first seen at M → word written at M, `q_valid`=1 at M+1.
- The next request toggle may occur at M (back-to-back) when FIFO space permits, counting the word being written at M.
- `rd` at cycle K → `q` shows the next byte at K+1. Sustained throughput is 1 byte/cycle while the FIFO is non-empty.
- Final-byte pop at K → `done`=1 at K+1 only, `busy`=0 at K+1, `q_valid`=0 at K+1.
- Ack and `rd`/pop in the same cycle: both take effect. Occupancy is unchanged, and a full FIFO does not lose data.
- Pointer increment wraps mod 2^24 words; termination depends only on the counter.

## Test plan
- Aligned range: `start_addr`=0x000100, `end_addr`=0x00010B, controller model acks after 6 cycles with words 0x03020100, 0x07060504, 0x0B0A0908, `rd` held high → exactly 3 requests (0x100, 0x104, 0x108), `q` sequence 0x00…0x0B, `done` one cycle after the byte 0x0B pop.
- Unaligned range: `start_addr`=0x000202, `end_addr`=0x000205 → 2 requests; bytes are lanes 2,3 of word 0x200 then lanes 0,1 of word 0x204; lanes 2,3 of word 0x204 are never presented.
- Backpressure: 32-byte range with `rd`=0 → requests stop after `FIFO_DEPTH`=4 words; releasing `rd` resumes requests, no word is lost or duplicated, all 32 bytes are delivered in order.
- Restart in flight: `start` to 0x1000, then a second `start` to 0x2000 while a request is outstanding → the outstanding word is discarded, the next `mem_addr` is 0x2000, no byte from 0x1000 is delivered, and `done` pulses once, for the second range only.
- `stop` mid-stream plus reset: `stop` with a request outstanding → `busy` stays 1 until the ack, then 0, and `done` never pulses. `init_n` low mid-run → all outputs reach reset values immediately.
- Empty range: `end_addr`<`start_addr` → no `mem_req` toggle, `done` at N+1, `busy` stays 0.

Source files
------------

// File: rtl/sdram_sample_prefetch.sv
// rtl/sdram_sample_prefetch.sv - streaming byte reader over a 32-bit toggle-handshake SDRAM port
// Fetches whole words into a small FIFO and hands the byte range out one byte per pop.
module sdram_sample_prefetch #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        start,
    input  logic        stop,
    input  logic [25:0] start_addr,
    input  logic [25:0] end_addr,
    input  logic        rd,
    output logic [7:0]  q,
    output logic        q_valid,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [25:0] mem_addr,
    input  logic [31:0] mem_q
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;
    state_t state_q, state_d;

    logic        req_q, req_d, wait_q, wait_d, pend_q, pend_d, done_q, done_d;
    logic [23:0] maddr_q, maddr_d, ptr_q, ptr_d;
    logic [24:0] cnt_q, cnt_d, new_cnt;
    logic [1:0]  lane_q, lane_d;
    logic [25:0] baddr_q, baddr_d, last_q, last_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   occ_q, occ_d, occ_after;
    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [31:0] head;
    logic outst, ack_evt, fifo_wr, pop_byte, pop_word, last_byte, issue;

    assign outst     = req_q != mem_ack;
    assign new_cnt   = (end_addr < start_addr) ? '0
                     : ({1'b0, end_addr[25:2]} - {1'b0, start_addr[25:2]} + 25'd1);
    // wait_q marks an outstanding request we issued, so its return is a real word
    assign ack_evt   = wait_q && !outst;
    assign last_byte = baddr_q == last_q;
    assign head      = fifo_mem[rp_q];
    assign pop_byte  = rd && q_valid && !start && !stop;
    assign pop_word  = pop_byte && (lane_q == 2'd3 || last_byte);
    assign fifo_wr   = ack_evt && state_q == RUN && !start && !stop;
    assign occ_after = occ_q + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, pop_word};
    assign issue     = state_q == RUN && !start && !stop && !outst
                    && cnt_q != '0 && occ_after < DEPTH_W;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            maddr_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            baddr_q <= '0;
            last_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            maddr_q <= maddr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            baddr_q <= baddr_d;
            last_q  <= last_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wp_q] <= mem_q;
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (start && (state_q != IDLE || new_cnt != '0)) begin
            pend_d  = new_cnt != '0;
            state_d = outst ? FLUSH : ((new_cnt != '0) ? RUN : IDLE);
        end else if (stop && state_q != IDLE) begin
            pend_d  = 1'b0;
            state_d = outst ? FLUSH : IDLE;
        end else begin
            case (state_q)
                RUN:     if (pop_byte && last_byte) state_d = IDLE;
                FLUSH:   if (!outst) state_d = pend_q ? RUN : IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        q_valid = state_q == RUN && occ_q != '0;
        busy    = state_q != IDLE;
        done_d  = (state_q == IDLE && start && new_cnt == '0) || (pop_byte && last_byte);
        case (lane_q)
            2'd0:    q = head[7:0];
            2'd1:    q = head[15:8];
            2'd2:    q = head[23:16];
            default: q = head[31:24];
        endcase
        if (!q_valid) q = '0;
    end

    always_comb begin
        req_d   = req_q;
        maddr_d = maddr_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        baddr_d = baddr_q;
        last_d  = last_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        occ_d   = occ_q;
        wait_d  = outst ? wait_q : 1'b0;
        if (start) begin
            ptr_d   = start_addr[25:2];
            cnt_d   = new_cnt;
            lane_d  = start_addr[1:0];
            baddr_d = start_addr;
            last_d  = end_addr;
            wp_d    = '0;
            rp_d    = '0;
            occ_d   = '0;
            // first request goes out in the start cycle itself when the port is free
            if (new_cnt != '0 && !outst) begin
                req_d   = ~req_q;
                maddr_d = start_addr[25:2];
                ptr_d   = start_addr[25:2] + 24'd1;
                cnt_d   = new_cnt - 25'd1;
                wait_d  = 1'b1;
            end
        end else if (stop) begin
            wp_d  = '0;
            rp_d  = '0;
            occ_d = '0;
        end else begin
            if (issue) begin
                req_d   = ~req_q;
                maddr_d = ptr_q;
                ptr_d   = ptr_q + 24'd1;
                cnt_d   = cnt_q - 25'd1;
                wait_d  = 1'b1;
            end
            if (fifo_wr) wp_d = wp_q + AW'(1);
            if (pop_byte) begin
                lane_d  = lane_q + 2'd1;
                baddr_d = baddr_q + 26'd1;
            end
            if (pop_word) rp_d = rp_q + AW'(1);
            occ_d = occ_after;
        end
    end

    assign done     = done_q;
    assign mem_req  = req_q;
    assign mem_addr = {maddr_q, 2'b00};
endmodule
